lcd_hd44780_ctrl: RTL and testbench

- Hardware HD44780-compatible character-LCD driver. It is the consumer end of the CPU-facing LCD register path: software hands it one byte per command (RS + 8-bit data) over a valid/ready handshake.
- The block generates the panel's RS/RW/EN/DATA timing and enforces per-command execution delays.
- Its packed pin word uses the same bit layout as the LSU's LCD register, so it can replace software bit-banging.

---
 rtl/lcd_hd44780_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller with per-command execution waits.
// Optional power-on init sequence: define LCD_AUTO_INIT_EN.
module lcd_hd44780_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned T_SETUP_NS  = 60,
  parameter int unsigned T_EN_NS     = 460,
  parameter int unsigned T_HOLD_NS   = 20,
  parameter int unsigned T_CMD_US    = 40,
  parameter int unsigned T_CLR_US    = 1640,
  parameter int unsigned T_INIT_US   = 4100,
  parameter int unsigned T_PWR_MS    = 15
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic [31:0] o_lcd_pins
);

  function automatic int unsigned cyc(
    input longint unsigned t,
    input longint unsigned unit
  );
    longint unsigned c;
    c = (t * CLK_FREQ_HZ + unit - 1) / unit;
    return (c == 0) ? 32'd1 : 32'(c);
  endfunction

  function automatic int unsigned mx(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned C_S    = cyc(T_SETUP_NS, 1_000_000_000);
  localparam int unsigned C_E    = cyc(T_EN_NS, 1_000_000_000);
  localparam int unsigned C_H    = cyc(T_HOLD_NS, 1_000_000_000);
  localparam int unsigned C_CMD  = cyc(T_CMD_US, 1_000_000);
  localparam int unsigned C_CLR  = cyc(T_CLR_US, 1_000_000);
  localparam int unsigned C_INIT = cyc(T_INIT_US, 1_000_000);
  localparam int unsigned C_PWR  = cyc(T_PWR_MS, 1_000);

  localparam int unsigned C_MAX =
    mx(mx(mx(C_S, C_E), mx(C_H, C_CMD)),
       mx(mx(C_CLR, C_INIT), C_PWR));
  localparam int CW = (C_MAX > 1) ? $clog2(C_MAX) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t L_S   = cnt_t'(C_S - 1);
  localparam cnt_t L_E   = cnt_t'(C_E - 1);
  localparam cnt_t L_H   = cnt_t'(C_H - 1);
  localparam cnt_t L_CMD = cnt_t'(C_CMD - 1);
  localparam cnt_t L_CLR = cnt_t'(C_CLR - 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    IDLE,
    SETUP,
    EN_HIGH,
    HOLD,
    EXEC
  } state_t;

  state_t     state, state_n;
  cnt_t       cnt, cnt_n;
  logic       rs_q, rs_n;
  logic [7:0] data_q, data_n;
  logic       en_q, on_q, done_q, busy_q;
  logic       is_clr;
  cnt_t       exec_ld;

`ifdef LCD_AUTO_INIT_EN
  localparam cnt_t L_INIT = cnt_t'(C_INIT - 1);
  localparam cnt_t L_PWR  = cnt_t'(C_PWR - 1);
  localparam state_t RST_STATE = PWR_WAIT;
  localparam cnt_t   RST_CNT   = L_PWR;

  logic [2:0] idx, idx_n;
  logic       done_n;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd4:    return 8'h0C;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      default: return 8'h38;
    endcase
  endfunction
`else
  localparam state_t RST_STATE = IDLE;
  localparam cnt_t   RST_CNT   = '0;
`endif

  // Clear and return-home are the two slow instructions.
  assign is_clr = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_comb begin
    exec_ld = is_clr ? L_CLR : L_CMD;
`ifdef LCD_AUTO_INIT_EN
    if (!done_q && idx < 3'd2) exec_ld = L_INIT;
`endif
  end

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == '0) ? cnt : cnt - cnt_t'(1);
    rs_n    = rs_q;
    data_n  = data_q;
`ifdef LCD_AUTO_INIT_EN
    idx_n   = idx;
    done_n  = done_q;
`endif
    unique case (state)
`ifdef LCD_AUTO_INIT_EN
      PWR_WAIT: if (cnt == '0) begin
        state_n = SETUP;
        cnt_n   = L_S;
        rs_n    = 1'b0;
        data_n  = init_byte(3'd0);
        idx_n   = 3'd0;
      end
`endif
      IDLE: if (i_req_valid && o_req_ready) begin
        state_n = SETUP;
        cnt_n   = L_S;
        rs_n    = i_req_rs;
        data_n  = i_req_data;
      end
      SETUP: if (cnt == '0) begin
        state_n = EN_HIGH;
        cnt_n   = L_E;
      end
      EN_HIGH: if (cnt == '0) begin
        state_n = HOLD;
        cnt_n   = L_H;
      end
      HOLD: if (cnt == '0) begin
        state_n = EXEC;
        cnt_n   = exec_ld;
      end
      EXEC: if (cnt == '0) begin
`ifdef LCD_AUTO_INIT_EN
        if (!done_q && idx != 3'd6) begin
          state_n = SETUP;
          cnt_n   = L_S;
          idx_n   = idx + 3'd1;
          data_n  = init_byte(idx + 3'd1);
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = RST_STATE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= RST_STATE;
      cnt    <= RST_CNT;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      en_q   <= 1'b0;
      on_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef LCD_AUTO_INIT_EN
      idx    <= 3'd0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rs_q   <= rs_n;
      data_q <= data_n;
      en_q   <= (state_n == EN_HIGH);
      on_q   <= 1'b1;
      busy_q <= (state_n != IDLE);
`ifdef LCD_AUTO_INIT_EN
      idx    <= idx_n;
      done_q <= done_n;
`else
      done_q <= 1'b1;
`endif
    end
  end

  assign o_req_ready = (state == IDLE) && done_q;
  assign o_busy      = busy_q;
  assign o_init_done = done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;
  assign o_lcd_pins  = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: cycle-level timing model plus literal checks.
// Follows LCD_AUTO_INIT_EN when the same macro is defined for the bench.
module tb_lcd_hd44780_ctrl;

  localparam int S = 1, E = 1, H = 1;
  localparam int CMD = 40, CLR = 1640;
  localparam int INIT = 4100, PWR = 15000;
`ifdef LCD_AUTO_INIT_EN
  localparam int DONE_AT = 25021;
`else
  localparam int DONE_AT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid = 1'b0;
  logic        rs = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ready, busy, done, on, en, lrs, rw;
  logic [7:0]  ldata;
  logic [31:0] pins;

  lcd_hd44780_ctrl #(.CLK_FREQ_HZ(1_000_000)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_valid(valid), .o_req_ready(ready),
    .i_req_rs(rs), .i_req_data(data),
    .o_busy(busy), .o_init_done(done),
    .o_lcd_on(on), .o_lcd_en(en),
    .o_lcd_rs(lrs), .o_lcd_rw(rw),
    .o_lcd_data(ldata), .o_lcd_pins(pins)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int tot_n  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: t counts edges since reset release; one command in flight,
  // issued at edge ca, spends S/E/H/cx cycles in its phases.
  longint     t, ca;
  bit         have, mdone, acc_m;
  bit         crs;
  logic [7:0] cd;
  int         cx, ik;
  logic [7:0] ib [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int xw(input bit r, input logic [7:0] d, input int k);
    if (k >= 0 && k < 2) return INIT;
    if (!r && d >= 8'd1 && d <= 8'd3) return CLR;
    return CMD;
  endfunction

  function automatic longint cmd_end();
    return ca + S + E + H + cx;
  endfunction

  function automatic bit m_ready();
    return mdone && (!have || t >= cmd_end());
  endfunction

  task automatic issue_init(input int k);
    have = 1; ca = t; crs = 0; cd = ib[k]; cx = xw(0, ib[k], k);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t = 0; ca = 0; have = 0; mdone = 0; ik = 0;
      crs = 0; cd = 8'h00; cx = 0;
    end else begin
      acc_m = valid && m_ready();
      t++;
      if (acc_m) begin
        have = 1; ca = t; crs = rs; cd = data; cx = xw(rs, data, -1);
      end
`ifdef LCD_AUTO_INIT_EN
      if (t == PWR) issue_init(0);
      else if (ik < 7 && have && t == cmd_end()) begin
        if (ik == 6) begin
          mdone = 1; ik = 7;
        end else begin
          ik++; issue_init(ik);
        end
      end
`else
      if (t == 1) mdone = 1;
`endif
    end
  end

  always @(negedge clk) begin
    bit         x_on, x_en, x_rdy, x_busy, x_rs;
    logic [7:0] x_d;
    x_on   = (t >= 1);
    x_rdy  = m_ready();
    x_busy = (t >= 1) && !x_rdy;
    x_en   = have && t >= ca + S && t < ca + S + E;
    x_rs   = have ? crs : 1'b0;
    x_d    = have ? cd : 8'h00;
    chk("cycle_ctl",
        {17'd0, busy, done, ready, on, en, lrs, rw, ldata},
        {17'd0, x_busy, mdone, x_rdy, x_on, x_en, x_rs, 1'b0, x_d});
    chk("cycle_pins", pins, {x_on, 20'd0, x_en, x_rs, 1'b0, x_d});
  end

  int         pulses = 0;
  logic [7:0] last_pd = 8'h00;
  logic       en_d = 1'b0;

  always @(negedge clk) begin
    if (en && !en_d) begin
      pulses++;
      last_pd = ldata;
    end
    en_d = en;
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 5000) begin
      @(negedge clk); n++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue_cmd(input bit r, input logic [7:0] d);
    wait_ready();
    valid = 1; rs = r; data = d;
    @(negedge clk);
    valid = 0;
  endtask

  task automatic measure(output int n);
    n = 0;
    while (!ready && n < 5000) begin
      @(negedge clk); n++;
    end
  endtask

  logic [7:0] tdat [4] = '{8'h01, 8'h02, 8'h04, 8'h00};
  int         texp [4] = '{1643, 1643, 43, 43};

  initial begin
    int n, p0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {24'd0, busy, done, ready, on, en, lrs, rw, 1'b0},
        32'd0);
    chk("reset_pins", pins, 32'd0);
    rstn = 1;
    n = 0;
    while (!done && n < 40000) begin
      @(negedge clk); n++;
    end
    chk("init_done_cycle", 32'(n), 32'(DONE_AT));
    chk("lcd_on", {31'd0, on}, 32'd1);

    issue_cmd(1, 8'h41);
    chk("wr_setup", {22'd0, en, lrs, ldata}, {22'd0, 1'b0, 1'b1, 8'h41});
    @(negedge clk);
    chk("wr_en_high", {31'd0, en}, 32'd1);
    chk("wr_pins", pins, 32'h8000_0641);
    @(negedge clk);
    chk("wr_hold", {31'd0, en}, 32'd0);
    n = 2;
    while (!ready && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("wr_ready_lat", 32'(n), 32'd43);

    for (int i = 0; i < 4; i++) begin
      issue_cmd(0, tdat[i]);
      measure(n);
      chk($sformatf("exec_%02h", tdat[i]), 32'(n), 32'(texp[i]));
    end

    issue_cmd(1, 8'h30);
    p0 = pulses;
    valid = 1; n = 0;
    while (!ready && n < 5000) begin
      rs = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      @(negedge clk); n++;
    end
    rs = 1; data = 8'h5A;
    @(negedge clk);
    valid = 0; data = 8'hFF;
    repeat (50) @(negedge clk);
    chk("hs_pulses", 32'(pulses - p0), 32'd2);
    chk("hs_byte", {24'd0, last_pd}, 32'h5A);

    repeat (4000) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) == 0);
      rs = 1'($urandom_range(0, 1));
      data = 8'($urandom);
    end
    @(negedge clk);
    valid = 0;
    wait_ready();

    issue_cmd(1, 8'h77);
    @(negedge clk);
    chk("pre_rst_en", {31'd0, en}, 32'd1);
    #2 rstn = 0;
    #1 chk("async_en_drop", {31'd0, en}, 32'd0);
    chk("async_pins", pins, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1;
    p0 = pulses;
    repeat (100) @(negedge clk);
    chk("post_rst_no_pulse", 32'(pulses - p0), 32'd0);
    n = 0;
    while (!done && n < 40000) begin
      @(negedge clk); n++;
    end
    chk("reinit_done", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
